// File: rtl/oam_dma_ctrl.sv
// Sprite DMA engine: on a CPU write to DMA_REG_ADDR it stalls the CPU and copies
// one page of CPU memory into OAM starting at the sampled OAMADDR.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | waiting for a CPU write to the DMA register
//   S_HALT  | CPU stalled, first cycle of the transfer
//   S_ALIGN | extra wait cycle when the trigger landed on an odd cycle
//   S_READ  | read strobe to CPU memory at {page, idx}
//   S_WRITE | write returned byte to OAM at base + idx
//   S_DONE  | one-cycle completion pulse, CPU released
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
  parameter bit          ALIGN_EN     = 1'b1,
  parameter int          BYTES        = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  data_in,
  input  logic        RWE,
  input  logic [7:0]  oam_addr_base,
  output logic        cpu_stall,
  output logic [15:0] dma_addr,
  output logic        dma_rd,
  input  logic [7:0]  mem_data,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_data,
  output logic        oam_we,
  output logic        dma_busy,
  output logic        dma_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_HALT, S_ALIGN, S_READ, S_WRITE, S_DONE
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(BYTES - 1);

  state_t      state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  base_q, base_d;
  logic [7:0]  idx_q, idx_d;
  logic        odd_q, odd_d;
  logic        par_q;
  logic [15:0] dma_addr_q, dma_addr_d;
  logic [7:0]  oam_addr_q, oam_addr_d;
  logic [7:0]  oam_data_q, oam_data_d;
  logic        trig;

  assign trig = (state_q == S_IDLE) && (cpu_addr == DMA_REG_ADDR) && RWE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      page_q     <= '0;
      base_q     <= '0;
      idx_q      <= '0;
      odd_q      <= 1'b0;
      par_q      <= 1'b0;
      dma_addr_q <= '0;
      oam_addr_q <= '0;
      oam_data_q <= '0;
    end else begin
      state_q    <= state_d;
      page_q     <= page_d;
      base_q     <= base_d;
      idx_q      <= idx_d;
      odd_q      <= odd_d;
      par_q      <= ~par_q;
      dma_addr_q <= dma_addr_d;
      oam_addr_q <= oam_addr_d;
      oam_data_q <= oam_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    base_d  = base_q;
    idx_d   = idx_q;
    odd_d   = odd_q;
    unique case (state_q)
      S_IDLE: begin
        if (trig) begin
          page_d  = data_in;
          base_d  = oam_addr_base;
          idx_d   = '0;
          odd_d   = par_q;
          state_d = S_HALT;
        end
      end
      S_HALT:  state_d = (ALIGN_EN && odd_q) ? S_ALIGN : S_READ;
      S_ALIGN: state_d = S_READ;
      S_READ:  state_d = S_WRITE;
      S_WRITE: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = S_READ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Address registers load on entry to their strobe state so they are valid
  // with the strobe and hold afterwards.
  always_comb begin
    dma_addr_d = dma_addr_q;
    oam_addr_d = oam_addr_q;
    oam_data_d = oam_data_q;
    if (state_d == S_READ && state_q != S_READ)
      dma_addr_d = {page_q, idx_d};
    if (state_d == S_WRITE && state_q != S_WRITE)
      oam_addr_d = base_q + idx_d;
    if (state_q == S_WRITE)
      oam_data_d = mem_data;
  end

  always_comb begin
    cpu_stall = 1'b0;
    dma_busy  = 1'b0;
    dma_rd    = 1'b0;
    oam_we    = 1'b0;
    dma_done  = 1'b0;
    unique case (state_q)
      S_HALT, S_ALIGN: begin
        cpu_stall = 1'b1;
        dma_busy  = 1'b1;
      end
      S_READ: begin
        cpu_stall = 1'b1;
        dma_busy  = 1'b1;
        dma_rd    = 1'b1;
      end
      S_WRITE: begin
        cpu_stall = 1'b1;
        dma_busy  = 1'b1;
        oam_we    = 1'b1;
      end
      S_DONE:  dma_done = 1'b1;
      default: ;
    endcase
  end

  // Read data arrives during WRITE, so it is forwarded straight through.
  assign oam_data = (state_q == S_WRITE) ? mem_data : oam_data_q;
  assign dma_addr = dma_addr_q;
  assign oam_addr = oam_addr_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: one task per scenario, expected values
// hand-computed from the transfer rules and a fixed memory pattern.
module tb_oam_dma_ctrl;

  logic        clk;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  data_in;
  logic        RWE;
  logic [7:0]  oam_addr_base;
  logic        cpu_stall;
  logic [15:0] dma_addr;
  logic        dma_rd;
  logic [7:0]  mem_data;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_data;
  logic        oam_we;
  logic        dma_busy;
  logic        dma_done;

  int checks = 0;
  int errors = 0;
  int cyc;

  int stall_n, busy_n, n_rd, n_wr, overlap, first_rd, done_n, done_k, rst_k;
  logic [3:0]  rst_snap;
  logic [7:0]  wr_addr [0:299];
  logic [7:0]  wr_data [0:299];
  logic [15:0] rd_addr [0:299];

  oam_dma_ctrl dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .data_in(data_in), .RWE(RWE),
    .oam_addr_base(oam_addr_base), .cpu_stall(cpu_stall), .dma_addr(dma_addr),
    .dma_rd(dma_rd), .mem_data(mem_data), .oam_addr(oam_addr), .oam_data(oam_data),
    .oam_we(oam_we), .dma_busy(dma_busy), .dma_done(dma_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory pattern: page 02 holds i at offset i; other pages are XOR-tagged.
  function automatic logic [7:0] mem_f(input logic [15:0] a);
    return a[7:0] ^ (a[15:8] - 8'd2);
  endfunction

  always @(posedge clk) if (dma_rd) mem_data <= mem_f(dma_addr);

  // Edges since reset release; its LSB is the parity seen at the next edge.
  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  task automatic do_trigger(input logic [7:0] pg, input logic [7:0] base, input bit want_odd);
    @(negedge clk);
    if (cyc[0] != want_odd) @(negedge clk);
    cpu_addr = 16'h4014; data_in = pg; oam_addr_base = base; RWE = 1'b1;
    @(posedge clk);
    #1;
    RWE = 1'b0; cpu_addr = 16'h0000;
  endtask

  // Samples every negedge after the trigger edge; k counts clocks after it.
  task automatic run_xfer(input int retrig_at, input int rst_at, input bit btb);
    bit rel = 0;
    stall_n = 0; busy_n = 0; n_rd = 0; n_wr = 0; overlap = 0;
    first_rd = -1; done_n = 0; done_k = 0; rst_k = 0; rst_snap = 4'hF;
    for (int k = 1; k <= 600; k++) begin
      @(negedge clk);
      if (rel) begin RWE = 1'b0; cpu_addr = 16'h0000; rel = 0; end
      if (cpu_stall) stall_n++;
      if (dma_busy) busy_n++;
      if (dma_rd && oam_we) overlap++;
      if (dma_rd) begin
        if (first_rd < 0) first_rd = k;
        if (n_rd < 300) rd_addr[n_rd] = dma_addr;
        n_rd++;
      end
      if (oam_we) begin
        if (n_wr < 300) begin wr_addr[n_wr] = oam_addr; wr_data[n_wr] = oam_data; end
        n_wr++;
      end
      if (dma_done) begin
        done_n++;
        if (done_k == 0) done_k = k;
      end
      if (retrig_at >= 0 && dma_rd && n_rd == retrig_at + 1) begin
        cpu_addr = 16'h4014; data_in = 8'h03; RWE = 1'b1; rel = 1;
      end
      if (btb && dma_done) begin
        cpu_addr = 16'h4014; data_in = 8'h03; oam_addr_base = 8'h10; RWE = 1'b1;
      end
      if (rst_at >= 0 && dma_rd && n_rd == rst_at + 1) begin
        reset = 1'b1;
        #1;
        rst_snap = {cpu_stall, oam_we, dma_rd, dma_busy};
        rst_k = k;
      end
      if (rst_k > 0 && k == rst_k + 2) reset = 1'b0;
      if (rst_k > 0 && k >= rst_k + 30) break;
      if (done_k > 0 && k > done_k) break;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({cpu_stall, dma_rd, oam_we, dma_busy, dma_done} !== 5'b0) begin
      errors++; $display("FAIL reset_strobes got %b exp 00000", {cpu_stall, dma_rd, oam_we, dma_busy, dma_done});
    end
    checks++;
    if ({dma_addr, oam_addr, oam_data} !== 32'h0) begin
      errors++; $display("FAIL reset_addr_data got %h exp 00000000", {dma_addr, oam_addr, oam_data});
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cpu_stall, dma_busy} !== 2'b0) begin
      errors++; $display("FAIL post_reset_idle got %b exp 00", {cpu_stall, dma_busy});
    end
  endtask

  task automatic test_nomatch;
    logic [4:0] act = '0;
    @(negedge clk);
    cpu_addr = 16'h4015; data_in = 8'h02; RWE = 1'b1;
    @(negedge clk);
    act |= {cpu_stall, dma_rd, oam_we, dma_busy, dma_done};
    cpu_addr = 16'h4014; RWE = 1'b0;
    @(negedge clk);
    cpu_addr = 16'h0000;
    repeat (6) begin
      @(negedge clk);
      act |= {cpu_stall, dma_rd, oam_we, dma_busy, dma_done};
    end
    checks++;
    if (act !== 5'b0) begin
      errors++; $display("FAIL nomatch_activity got %b exp 00000", act);
    end
  endtask

  task automatic test_even;
    int bad = 0;
    do_trigger(8'h02, 8'h00, 1'b0);
    run_xfer(-1, -1, 1'b0);
    checks++;
    if (stall_n !== 513) begin errors++; $display("FAIL even_stall got %0d exp 513", stall_n); end
    checks++;
    if (busy_n !== 513) begin errors++; $display("FAIL even_busy got %0d exp 513", busy_n); end
    checks++;
    if (n_wr !== 256) begin errors++; $display("FAIL even_nwr got %0d exp 256", n_wr); end
    for (int i = 0; i < 256; i++)
      if (wr_addr[i] !== 8'(i) || wr_data[i] !== 8'(i)) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL even_oam_bytes got %0d bad writes exp 0", bad); end
    checks++;
    if (done_n !== 1 || done_k !== 514) begin
      errors++; $display("FAIL even_done got n=%0d at=%0d exp n=1 at=514", done_n, done_k);
    end
    checks++;
    if (first_rd !== 2) begin errors++; $display("FAIL even_first_rd got %0d exp 2", first_rd); end
    checks++;
    if (overlap !== 0) begin errors++; $display("FAIL even_strobe_overlap got %0d exp 0", overlap); end
  endtask

  task automatic test_odd;
    do_trigger(8'h02, 8'h00, 1'b1);
    run_xfer(-1, -1, 1'b0);
    checks++;
    if (stall_n !== 514) begin errors++; $display("FAIL odd_stall got %0d exp 514", stall_n); end
    checks++;
    if (first_rd !== 3) begin errors++; $display("FAIL odd_first_rd got %0d exp 3", first_rd); end
    checks++;
    if (rd_addr[0] !== 16'h0200) begin errors++; $display("FAIL odd_first_addr got %h exp 0200", rd_addr[0]); end
    checks++;
    if (done_k !== 515 || n_wr !== 256) begin
      errors++; $display("FAIL odd_done got at=%0d nwr=%0d exp at=515 nwr=256", done_k, n_wr);
    end
  endtask

  task automatic test_wrap;
    do_trigger(8'h07, 8'hFC, 1'b0);
    run_xfer(-1, -1, 1'b0);
    checks++;
    if (n_wr !== 256) begin errors++; $display("FAIL wrap_nwr got %0d exp 256", n_wr); end
    checks++;
    if (wr_addr[0] !== 8'hFC || wr_data[0] !== 8'h05) begin
      errors++; $display("FAIL wrap_first got %h/%h exp fc/05", wr_addr[0], wr_data[0]);
    end
    checks++;
    if (wr_addr[4] !== 8'h00 || wr_data[4] !== 8'h01) begin
      errors++; $display("FAIL wrap_fifth got %h/%h exp 00/01", wr_addr[4], wr_data[4]);
    end
    checks++;
    if (wr_addr[255] !== 8'hFB || wr_data[255] !== 8'hFA) begin
      errors++; $display("FAIL wrap_last got %h/%h exp fb/fa", wr_addr[255], wr_data[255]);
    end
    checks++;
    if (rd_addr[255] !== 16'h07FF) begin errors++; $display("FAIL wrap_last_rd got %h exp 07ff", rd_addr[255]); end
  endtask

  task automatic test_retrigger;
    int bad = 0;
    do_trigger(8'h02, 8'h00, 1'b0);
    run_xfer(10, -1, 1'b0);
    for (int i = 0; i < 256; i++)
      if (rd_addr[i] !== (16'h0200 | 16'(i)) || wr_data[i] !== 8'(i)) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL retrig_page got %0d bad accesses exp 0", bad); end
    checks++;
    if (n_rd !== 256 || stall_n !== 513) begin
      errors++; $display("FAIL retrig_len got rd=%0d stall=%0d exp rd=256 stall=513", n_rd, stall_n);
    end
  endtask

  task automatic test_back_to_back;
    bit odd;
    do_trigger(8'h02, 8'h00, 1'b0);
    run_xfer(-1, -1, 1'b1);
    checks++;
    if (cpu_stall !== 1'b0 || done_k !== 514) begin
      errors++; $display("FAIL btb_done_ignored got stall=%b at=%0d exp stall=0 at=514", cpu_stall, done_k);
    end
    odd = cyc[0];
    @(posedge clk);
    #1;
    RWE = 1'b0; cpu_addr = 16'h0000;
    run_xfer(-1, -1, 1'b0);
    checks++;
    if (stall_n !== 513 + int'(odd)) begin
      errors++; $display("FAIL btb_second_stall got %0d exp %0d", stall_n, 513 + int'(odd));
    end
    checks++;
    if (rd_addr[0] !== 16'h0300 || wr_addr[0] !== 8'h10 || wr_data[0] !== 8'h01) begin
      errors++; $display("FAIL btb_second_first got %h/%h/%h exp 0300/10/01", rd_addr[0], wr_addr[0], wr_data[0]);
    end
  endtask

  task automatic test_reset_mid;
    do_trigger(8'h02, 8'h00, 1'b0);
    run_xfer(-1, 100, 1'b0);
    checks++;
    if (rst_snap !== 4'b0) begin errors++; $display("FAIL rstmid_drop got %b exp 0000", rst_snap); end
    checks++;
    if (n_wr !== 100 || n_rd !== 101 || done_n !== 0) begin
      errors++; $display("FAIL rstmid_abort got wr=%0d rd=%0d done=%0d exp 100/101/0", n_wr, n_rd, done_n);
    end
    do_trigger(8'h02, 8'h20, 1'b0);
    run_xfer(-1, -1, 1'b0);
    checks++;
    if (stall_n !== 513 || n_wr !== 256 || done_n !== 1) begin
      errors++; $display("FAIL rstmid_recover got stall=%0d wr=%0d done=%0d exp 513/256/1", stall_n, n_wr, done_n);
    end
    checks++;
    if (wr_addr[0] !== 8'h20 || wr_addr[255] !== 8'h1F || wr_data[255] !== 8'hFF) begin
      errors++; $display("FAIL rstmid_recover_data got %h %h/%h exp 20 1f/ff", wr_addr[0], wr_addr[255], wr_data[255]);
    end
  endtask

  initial begin
    reset = 1'b0; cpu_addr = 16'h0000; data_in = 8'h00; RWE = 1'b0;
    oam_addr_base = 8'h00; mem_data = 8'h00;
    #2 reset = 1'b1;
    test_reset;
    test_nomatch;
    test_even;
    test_odd;
    test_wrap;
    test_retrigger;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
- Sprite DMA engine that sits directly upstream of the PPU sprite path.
- A CPU write to the DMA register halts the CPU. The engine then copies one 256-byte page of CPU memory into sprite OAM, starting at the PPU's current OAMADDR and wrapping modulo 256, then releases the CPU.
- It drives the CPU-side memory read port and the OAM write port consumed by the sprite renderer.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address that triggers a transfer.
- ALIGN_EN, 1, when 1, inserts one extra wait cycle if the trigger lands on an odd cycle.
- BYTES, 256, bytes per transfer. Must be a power of two, at most 256.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cpu_addr  in  16  CPU address bus.
- data_in  in  8  CPU write data. Bits [7:0] give the source page.
- RWE  in  1  CPU write enable; 1 = write.
- oam_addr_base  in  8  PPU OAMADDR value, sampled at trigger.
- cpu_stall  out  1  halts the CPU while high.
- dma_addr  out  16  source read address to CPU memory.
- dma_rd  out  1  read strobe to CPU memory.
- mem_data  in  8  CPU memory read data; synchronous, valid 1 clk after dma_rd.
- oam_addr  out  8  OAM write address.
- oam_data  out  8  OAM write data.
- oam_we  out  1  OAM write strobe.
- dma_busy  out  1  high from trigger until the last OAM write completes.
- dma_done  out  1  one-clk pulse after the last write.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - Outputs: cpu_stall=0, dma_rd=0, oam_we=0, dma_busy=0, dma_done=0.
  - dma_addr=0, oam_addr=0, oam_data=0.
  - Byte counter idx=0, parity flop par=0.
- par toggles every clk in all states. It only matters at trigger time.
- Trigger: at posedge, state==IDLE and cpu_addr==DMA_REG_ADDR and RWE==1.
  - Latch page=data_in and base=oam_addr_base.
  - Set idx=0 and record odd=par.
  - Go to HALT.
- Triggers while not IDLE are ignored. Page and base are not modified.
- State machine (one state per clk):
  - IDLE: no outputs asserted.
  - HALT: cpu_stall=1, dma_busy=1. Go to ALIGN if ALIGN_EN and odd, otherwise go to READ.
  - ALIGN: cpu_stall=1, dma_busy=1. Go to READ.
  - READ:
    - cpu_stall=1, dma_busy=1.
    - dma_rd=1, dma_addr={page, idx[7:0]}.
    - Go to WRITE.
  - WRITE:
    - cpu_stall=1, dma_busy=1.
    - oam_we=1, oam_addr=base+idx (8-bit, wraps modulo 256), oam_data=mem_data.
    - If idx==BYTES-1, go to DONE. Otherwise idx<=idx+1 and go to READ.
  - DONE: cpu_stall=0, dma_busy=0, dma_done=1 for exactly one clk. Go to IDLE.
- Output timing:
  - cpu_stall, dma_busy, dma_rd and oam_we are registered, or decoded from registered state.
  - They rise in the clk after the trigger edge.
- Latency:
  - Stall length = 1 (HALT) + optional 1 (ALIGN) + 2*BYTES.
  - With BYTES=256 that is 513 clk for an even trigger and 514 clk for an odd trigger.
- dma_addr holds its last value when not in READ. Only dma_rd qualifies it.
- Strobe exclusivity:
  - oam_we is never asserted in the same clk as dma_rd.
  - No OAM write occurs outside WRITE.
- Wrap-around:
  - base=8'hFC writes OAM addresses FC, FD, FE, FF, 00, ... FB.
  - The source address never crosses the page boundary; idx wraps only within {page, 00..FF}.
- Back-to-back: a trigger in the clk where the state is DONE is ignored. A trigger in the next clk, once the state is IDLE, is accepted.
- Reset mid-transfer: immediate abort.
  - cpu_stall and all strobes drop asynchronously.
  - OAM keeps any bytes already written.
  - No dma_done pulse is generated.
- Simultaneous reset and trigger: reset wins.

Test Plan:
- Even trigger:
  - Stimulus: par=0, write 8'h02 to 16'h4014, oam_addr_base=0, source mem[16'h0200+i]=i.
  - Required: cpu_stall high for exactly 513 clk.
  - Required: 256 oam_we pulses, with oam_addr=i and oam_data=i.
  - Required: dma_done pulses once, 514 clk after the trigger edge.
- Odd trigger:
  - Stimulus: same transfer with par=1.
  - Required: an ALIGN cycle is present and cpu_stall is high for exactly 514 clk.
  - Required: first dma_rd occurs 3 clk after trigger, with dma_addr=16'h0200.
- OAMADDR wrap:
  - Stimulus: oam_addr_base=8'hFC, page 8'h07.
  - Required: first write goes to oam_addr=FC with data mem[16'h0700].
  - Required: 5th write goes to oam_addr=00 with data mem[16'h0704].
  - Required: last write goes to oam_addr=FB with data mem[16'h07FF].
- Ignored re-trigger:
  - Stimulus: write 8'h03 to 16'h4014 at idx=10 of a page-02 transfer.
  - Required: all 256 reads stay within 16'h0200–02FF and stall length is unchanged.
- Reset mid-operation:
  - Stimulus: assert reset at idx=100.
  - Required: cpu_stall=0 and oam_we=0 immediately, with no further writes and no dma_done.
  - Stimulus: a new trigger after reset is released.
  - Required: a full transfer completes normally.
- Non-matching access:
  - Stimulus: write to 16'h4015, and read (RWE=0) at 16'h4014.
  - Required: no stall, no strobes, state stays IDLE.
